// File: rtl/mips_muldiv_unit.sv
// ---------------------------------------------------------------------------
// mips_muldiv_unit
//
// Multi-cycle multiply/divide unit that owns the architectural HI/LO pair.
// Multiply is shift-add and divide is restoring. Each iterates one bit per
// cycle. Multiply can optionally complete in a single cycle (FAST_MUL=1).
// The control unit stalls MFHI/MFLO and new mul/div ops while busy is high.
//
// Parameters:
//   WIDTH    operand width; HI and LO are each WIDTH bits
//   FAST_MUL 1 = single-cycle multiply, 0 = iterative multiply
//
// Ports:
//   clk     in   clock, all state changes on the rising edge
//   reset   in   asynchronous active-high reset
//   start   in   request, accepted on a rising edge where busy=0
//   op      in   000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO
//   src_a   in   multiplicand / dividend / MTHI-MTLO data
//   src_b   in   multiplier / divisor
//   cancel  in   abort the in-flight op, HI/LO keep their pre-op values
//   busy    out  high while a mul/div op is in flight
//   done    out  one-cycle pulse when a result is written to HI/LO
//   hi, lo  out  architectural HI and LO registers
// ---------------------------------------------------------------------------
module mips_muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter int FAST_MUL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  // What the FIX edge does with the accumulator
  typedef enum logic [1:0] {
    FIX_RAW,
    FIX_MUL,
    FIX_DIV
  } fix_t;

  state_t             state;
  fix_t               fix_kind;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic [CNT_W-1:0]   cnt;
  logic               neg_lo;
  logic               neg_hi;

  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] fast_prod;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_quot;
  logic [WIDTH-1:0]   fix_rem;

  // Operand conditioning at accept time: signed ops work on magnitudes and
  // remember the signs so the FIX edge can restore them.
  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = is_signed & src_a[WIDTH-1];
    b_neg     = is_signed & src_b[WIDTH-1];
    mag_a     = a_neg ? -src_a : src_a;
    mag_b     = b_neg ? -src_b : src_b;
    fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
  end

  // One iteration step for each algorithm.
  // Multiply: acc = {partial sum, remaining multiplier bits}. The low bit
  // decides whether the multiplicand is added before the shift right.
  // Divide: acc = {partial remainder, remaining dividend / quotient bits}.
  // The trial subtraction borrows (msb set) when the divisor does not fit.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, operand};
  end

  // Sign restoration applied on the FIX edge
  always_comb begin
    fix_prod = neg_lo ? -acc : acc;
    fix_quot = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    fix_rem  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Main control and datapath. busy is registered and is high exactly when
  // the state is not IDLE, so "accept" reduces to start in IDLE. HI/LO are
  // only written by MTHI/MTLO or on the FIX edge, which keeps partial
  // results invisible and lets cancel leave HI/LO untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      fix_kind <= FIX_RAW;
      acc      <= '0;
      operand  <= '0;
      cnt      <= '0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt <= '0;
            case (op)
              OP_MULTU, OP_MULT: begin
                busy     <= 1'b1;
                fix_kind <= FIX_MUL;
                operand  <= mag_a;
                neg_lo   <= a_neg ^ b_neg;
                neg_hi   <= 1'b0;
                if (FAST_MUL != 0) begin
                  acc   <= fast_prod;
                  state <= S_FIX;
                end else begin
                  acc   <= {{WIDTH{1'b0}}, mag_b};
                  state <= S_MUL;
                end
              end
              OP_DIVU, OP_DIV: begin
                busy <= 1'b1;
                if (src_b == '0) begin
                  // Divide by zero skips iteration; the raw dividend goes to HI
                  acc      <= {src_a, {WIDTH{1'b1}}};
                  operand  <= '0;
                  fix_kind <= FIX_RAW;
                  neg_lo   <= 1'b0;
                  neg_hi   <= 1'b0;
                  state    <= S_FIX;
                end else begin
                  acc      <= {{WIDTH{1'b0}}, mag_a};
                  operand  <= mag_b;
                  fix_kind <= FIX_DIV;
                  neg_lo   <= a_neg ^ b_neg;
                  neg_hi   <= a_neg;
                  state    <= S_DIV;
                end
              end
              OP_MTHI: hi <= src_a;
              OP_MTLO: lo <= src_a;
              default: ;
            endcase
          end
        end

        S_MUL: begin
          if (cancel) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_ITER) state <= S_FIX;
          end
        end

        S_DIV: begin
          if (cancel) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            if (!div_trial[WIDTH])
              acc <= {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
              acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_ITER) state <= S_FIX;
          end
        end

        S_FIX: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          // cancel wins over completion: no write, no done
          if (!cancel) begin
            done <= 1'b1;
            case (fix_kind)
              FIX_MUL: {hi, lo} <= fix_prod;
              FIX_DIV: begin
                lo <= fix_quot;
                hi <= fix_rem;
              end
              default: {hi, lo} <= acc;
            endcase
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_muldiv_unit
//
// Self-checking bench for mips_muldiv_unit. An iterative instance and a
// FAST_MUL instance share clock, reset and operand buses but have their own
// start/cancel. Expected HI/LO come from plain 64-bit arithmetic on the
// instruction semantics, and latency comes from the op class.
// ---------------------------------------------------------------------------
module tb_mips_muldiv_unit;

  localparam int W = 32;
  localparam logic [2:0] OP_MULTU = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   op;
  logic [W-1:0] src_a, src_b;
  logic         start_s, start_f, cancel_s, cancel_f;
  logic         busy_s, busy_f, done_s, done_f;
  logic [W-1:0] hi_s, lo_s, hi_f, lo_f;

  mips_muldiv_unit #(.WIDTH(W), .FAST_MUL(0)) dut_slow (
    .clk(clk), .reset(reset), .start(start_s), .op(op),
    .src_a(src_a), .src_b(src_b), .cancel(cancel_s),
    .busy(busy_s), .done(done_s), .hi(hi_s), .lo(lo_s)
  );

  mips_muldiv_unit #(.WIDTH(W), .FAST_MUL(1)) dut_fast (
    .clk(clk), .reset(reset), .start(start_f), .op(op),
    .src_a(src_a), .src_b(src_b), .cancel(cancel_f),
    .busy(busy_f), .done(done_f), .hi(hi_f), .lo(lo_f)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  int           total = 0;
  int           bad = 0;
  bit           fast_sel = 1'b0;
  logic [W-1:0] model_hi [2];
  logic [W-1:0] model_lo [2];

  function automatic logic cur_busy();
    return fast_sel ? busy_f : busy_s;
  endfunction

  function automatic logic cur_done();
    return fast_sel ? done_f : done_s;
  endfunction

  function automatic logic [W-1:0] cur_hi();
    return fast_sel ? hi_f : hi_s;
  endfunction

  function automatic logic [W-1:0] cur_lo();
    return fast_sel ? lo_f : lo_s;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Architectural effect of one op on the selected unit's HI/LO
  task automatic modelOp(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        model_hi[fast_sel] = p[63:32];
        model_lo[fast_sel] = p[31:0];
      end
      OP_MULT: begin
        p = 64'(sa * sb);
        model_hi[fast_sel] = p[63:32];
        model_lo[fast_sel] = p[31:0];
      end
      OP_DIVU, OP_DIV: begin
        if (b == '0) begin
          model_hi[fast_sel] = a;
          model_lo[fast_sel] = '1;
        end else if (o == OP_DIVU) begin
          model_lo[fast_sel] = a / b;
          model_hi[fast_sel] = a % b;
        end else begin
          q = sa / sb;
          r = sa % sb;
          model_lo[fast_sel] = q[31:0];
          model_hi[fast_sel] = r[31:0];
        end
      end
      OP_MTHI: model_hi[fast_sel] = a;
      OP_MTLO: model_lo[fast_sel] = a;
      default: ;
    endcase
  endtask

  function automatic int expLatency(input logic [2:0] o, input logic [W-1:0] b);
    if ((o == OP_DIVU || o == OP_DIV) && b == '0) return 1;
    if ((o == OP_MULTU || o == OP_MULT) && fast_sel) return 1;
    return W + 1;
  endfunction

  // Presents one request for a single accept edge and drops start at edge+1
  task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    op    = o;
    src_a = a;
    src_b = b;
    if (fast_sel) start_f = 1'b1;
    else          start_s = 1'b1;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    start_f = 1'b0;
  endtask

  // Counts edges until done (bounded) and cycles with busy high
  task automatic waitDone(output int lat, output int bcnt);
    bit found = 1'b0;
    lat  = -1;
    bcnt = 0;
    for (int i = 1; i <= 80 && !found; i++) begin
      @(negedge clk);
      if (cur_busy()) bcnt++;
      @(posedge clk);
      #1;
      if (cur_done()) begin
        lat   = i;
        found = 1'b1;
      end
    end
  endtask

  task automatic runCheck(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int lat, bcnt, elat;
    elat = expLatency(o, b);
    applyStimulus(o, a, b);
    modelOp(o, a, b);
    if (o <= OP_DIV) begin
      waitDone(lat, bcnt);
      checkOutput({tag, "_latency"}, 64'(lat), 64'(elat));
      checkOutput({tag, "_busycycles"}, 64'(bcnt), 64'(elat));
      checkOutput({tag, "_hi"}, 64'(cur_hi()), 64'(model_hi[fast_sel]));
      checkOutput({tag, "_lo"}, 64'(cur_lo()), 64'(model_lo[fast_sel]));
      @(posedge clk);
      #1;
      checkOutput({tag, "_after"}, {62'b0, cur_busy(), cur_done()}, 64'd0);
    end else begin
      checkOutput({tag, "_hi"}, 64'(cur_hi()), 64'(model_hi[fast_sel]));
      checkOutput({tag, "_lo"}, 64'(cur_lo()), 64'(model_lo[fast_sel]));
      checkOutput({tag, "_idle"}, {62'b0, cur_busy(), cur_done()}, 64'd0);
      @(posedge clk);
      #1;
      checkOutput({tag, "_nodone"}, {62'b0, cur_busy(), cur_done()}, 64'd0);
    end
  endtask

  // Hang guard
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed cases, cancel/ignore/reset scenarios, then random traffic
  initial begin
    logic [2:0]   o;
    logic [W-1:0] a, b, a2, b2;
    int           lat, bcnt, dcnt;

    reset = 1'b1; start_s = 1'b0; start_f = 1'b0; cancel_s = 1'b0; cancel_f = 1'b0;
    op = '0; src_a = '0; src_b = '0;
    model_hi[0] = '0; model_lo[0] = '0; model_hi[1] = '0; model_lo[1] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_slow", {hi_s, lo_s}, 64'd0);
    checkOutput("rst_slow_ctl", {62'b0, busy_s, done_s}, 64'd0);
    checkOutput("rst_fast", {hi_f, lo_f}, 64'd0);
    checkOutput("rst_fast_ctl", {62'b0, busy_f, done_f}, 64'd0);

    fast_sel = 1'b0;
    runCheck(OP_MULT, 32'hFFFFFFFD, 32'd5, "mult_neg3x5");
    checkOutput("mult_neg3x5_val", {hi_s, lo_s}, 64'hFFFFFFFF_FFFFFFF1);
    runCheck(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
    checkOutput("divu_100_7_val", {hi_s, lo_s}, 64'h00000002_0000000E);
    runCheck(OP_DIV, 32'hFFFFFFF9, 32'd2, "div_neg7_2");
    checkOutput("div_neg7_2_val", {hi_s, lo_s}, 64'hFFFFFFFF_FFFFFFFD);
    runCheck(OP_DIV, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    checkOutput("div_ovf_val", {hi_s, lo_s}, 64'h00000000_80000000);
    runCheck(OP_DIVU, 32'h1234, 32'd0, "divu_zero");
    checkOutput("divu_zero_val", {hi_s, lo_s}, 64'h00001234_FFFFFFFF);
    runCheck(OP_MTHI, 32'hAAAA5555, 32'd0, "mthi");
    runCheck(OP_MTLO, 32'h0F0F0F0F, 32'd0, "mtlo");
    checkOutput("mthi_mtlo_val", {hi_s, lo_s}, 64'hAAAA5555_0F0F0F0F);
    runCheck(3'b110, 32'h12345678, 32'd3, "op110");
    runCheck(3'b111, 32'h12345678, 32'd3, "op111");

    // Cancel mid-multiply: HI/LO keep preloaded values, no done ever
    runCheck(OP_MTHI, 32'h11111111, 32'd0, "pre_hi");
    runCheck(OP_MTLO, 32'h22222222, 32'd0, "pre_lo");
    applyStimulus(OP_MULTU, 32'hDEADBEEF, 32'h12345678);
    repeat (9) @(posedge clk);
    @(negedge clk);
    cancel_s = 1'b1;
    @(posedge clk);
    #1;
    cancel_s = 1'b0;
    checkOutput("cancel_ctl", {62'b0, busy_s, done_s}, 64'd0);
    checkOutput("cancel_hilo", {hi_s, lo_s}, 64'h11111111_22222222);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done_s) dcnt++;
    end
    checkOutput("cancel_nodone", 64'(dcnt), 64'd0);

    // Start while busy is ignored; start held across the done edge is
    // taken one edge later
    a = $urandom; b = $urandom; a2 = $urandom; b2 = $urandom;
    applyStimulus(OP_MULT, a, b);
    repeat (5) @(posedge clk);
    @(negedge clk);
    op = OP_DIVU; src_a = $urandom; src_b = 32'd3; start_s = 1'b1;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    checkOutput("ignore_busy", 64'(busy_s), 64'd1);
    repeat (26) @(posedge clk);
    @(negedge clk);
    op = OP_MULTU; src_a = a2; src_b = b2; start_s = 1'b1;
    @(posedge clk);
    #1;
    modelOp(OP_MULT, a, b);
    checkOutput("first_done", {62'b0, busy_s, done_s}, 64'd1);
    checkOutput("first_val", {hi_s, lo_s}, {model_hi[0], model_lo[0]});
    @(posedge clk);
    #1;
    start_s = 1'b0;
    checkOutput("second_accept", 64'(busy_s), 64'd1);
    modelOp(OP_MULTU, a2, b2);
    waitDone(lat, bcnt);
    checkOutput("second_latency", 64'(lat), 64'(W + 1));
    checkOutput("second_val", {hi_s, lo_s}, {model_hi[0], model_lo[0]});

    // Fast multiply instance
    fast_sel = 1'b1;
    runCheck(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "fast_max");
    checkOutput("fast_max_val", {hi_f, lo_f}, 64'hFFFFFFFE_00000001);
    for (int n = 0; n < 8; n++) begin
      o = 3'($urandom_range(0, 3));
      runCheck(o, $urandom, $urandom, "fast_rnd");
    end

    // Async reset in the middle of a divide, observed between edges
    fast_sel = 1'b0;
    applyStimulus(OP_DIV, 32'h7654321, 32'd13);
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_hilo", {hi_s, lo_s}, 64'd0);
    checkOutput("async_rst_busy", 64'(busy_s), 64'd0);
    checkOutput("async_rst_fast", {hi_f, lo_f}, 64'd0);
    model_hi[0] = '0; model_lo[0] = '0; model_hi[1] = '0; model_lo[1] = '0;
    #4;
    reset = 1'b0;

    // Random traffic on the iterative unit with boundary operands mixed in
    for (int n = 0; n < 40; n++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      runCheck(o, a, b, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit owning the architectural HI/LO pair for the MIPS core.
- Replaces the ALU's single-cycle HILO logic with a parametrised iterative datapath: shift-add multiply and restoring divide, one bit per cycle.
- Adds a busy/done handshake, cancel, and defined divide-by-zero and overflow results.
- Sits beside mips_alu. The control unit stalls MFHI/MFLO and new mul/div ops while busy is high.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- FAST_MUL, 0, 1 = multiply completes in one cycle using the "*" operator; 0 = iterative multiply, one bit per cycle.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only on a rising edge where busy=0.
- op  input  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; 110/111 are ignored (no state change).
- src_a  input  WIDTH  multiplicand / dividend / MTHI-MTLO data; sampled at accept.
- src_b  input  WIDTH  multiplier / divisor; sampled at accept.
- cancel  input  1  abort the in-flight op; HI/LO keep their pre-op values.
- busy  output  1  high while a mul/div op is in flight.
- done  output  1  one-cycle pulse when a mul/div result is written to HI/LO.
- hi  output  WIDTH  architectural HI register.
- lo  output  WIDTH  architectural LO register.

Behaviour:
- Reset (async, any state): state=IDLE, hi=0, lo=0, busy=0, done=0; all internal accumulators and counters cleared.
- States: IDLE, MUL, DIV, FIX.
- Accept edge E0 (start=1, busy=0):
  - Operands latched.
  - For signed ops (MULT, DIV), magnitudes are taken and the result signs recorded.
- MTHI / MTLO:
  - hi (respectively lo) <= src_a at E0.
  - State stays IDLE; busy stays 0; no done pulse.
- MULT / MULTU with FAST_MUL=0:
  - IDLE->MUL at E0; busy=1 from E0.
  - One partial-product bit per edge, E1..E_WIDTH, using a 2*WIDTH-bit accumulator.
  - MUL->FIX at E_WIDTH.
  - At E_WIDTH+1 the 2's-complement fix-up is applied if signs differ, {hi,lo} is written, and the unit returns to IDLE.
- MULT / MULTU with FAST_MUL=1:
  - IDLE->FIX at E0; the full product is written at E1.
- DIV / DIVU:
  - IDLE->DIV at E0; restoring iterations E1..E_WIDTH; FIX at E_WIDTH+1 writes lo=quotient, hi=remainder.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero:
  - Detected at E0; unit goes IDLE->FIX directly.
  - At E1: lo = all ones, hi = src_a.
- Signed overflow (DIV, src_a = most-negative value, src_b = -1): lo = most-negative value, hi = 0, written via the normal iterative path.
- busy falls, and done=1 for exactly one cycle, after the FIX edge. hi/lo hold their old values until that edge; no partial results are ever visible.
- start while busy=1: ignored; operands are not sampled. The control unit must stall instead.
- Simultaneous start and done: the new op is not accepted that cycle (busy is still 1 at the sampling edge); it is accepted next cycle.
- cancel=1 while busy:
  - Next edge returns to IDLE, busy=0, no done pulse; hi/lo unchanged.
  - cancel in IDLE has no effect. cancel has priority over completion in FIX.
- Reset asserted mid-operation: immediate abort; hi/lo=0.
- Iteration counter: ceil(log2(WIDTH+1)) bits; it must not wrap across ops and is cleared at every accept.
- Latency from accept to result: WIDTH+1 edges for iterative mul/div, 1 edge for FAST_MUL multiply and divide by zero.

Test Plan:
- WIDTH=32, FAST_MUL=0: MULT src_a=FFFFFFFD (-3), src_b=5 -> done 33 edges after accept; hi=FFFFFFFF, lo=FFFFFFF1; busy high for exactly 33 cycles.
- DIVU 100/7 -> lo=0000000E, hi=00000002. DIV FFFFFFF9 (-7)/2 -> lo=FFFFFFFD, hi=FFFFFFFF.
- DIV 80000000/FFFFFFFF -> lo=80000000, hi=0. DIVU 1234/0 -> at accept+1 edge: lo=FFFFFFFF, hi=00001234, done pulse.
- MTHI AAAA5555 then MTLO 0F0F0F0F -> hi/lo update at the accept edge; busy and done never asserted.
- MULTU with hi/lo preloaded to 11111111/22222222: cancel at iteration 10 -> busy=0 next cycle, no done, hi/lo unchanged. A new start issued during busy is ignored and results reflect the first op only.
- FAST_MUL=1, MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001 one edge after accept. Async reset mid-DIV -> hi=lo=0 and busy=0 without waiting for a clock edge.
